// File: rtl/truth_table_scanner_pkg.sv
// Shared types and helpers for the truth-table scanner.
//   state_t  : scanner FSM states
//   minterms : minterm count for a given input count (2^n_in)
//   tt_index : bit position of output j, minterm m in a packed table
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned minterms(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic int unsigned tt_index(input int unsigned j,
                                           input int unsigned m,
                                           input int unsigned n_in);
    return j * minterms(n_in) + m;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Stimulus/response bus between the scanner and its environment.
//   start/exp      : scan request and expected table
//   f              : outputs of the block under test
//   x              : inputs driven onto the block under test
//   busy/done      : scan status
//   tt/mismatch/first_fail/fail_count : scan results
// The scanner uses the slave modport; the environment uses master.
interface truth_table_scanner_if
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2
);
  localparam int unsigned M  = minterms(N_IN);
  localparam int unsigned TW = N_OUT * M;

  logic              start;
  logic [TW-1:0]     exp;
  logic [N_OUT-1:0]  f;
  logic [N_IN-1:0]   x;
  logic              busy;
  logic              done;
  logic [TW-1:0]     tt;
  logic              mismatch;
  logic [N_IN-1:0]   first_fail;
  logic [N_IN:0]     fail_count;

  modport master (
    output start, exp, f,
    input  x, busy, done, tt, mismatch, first_fail, fail_count
  );

  modport slave (
    input  start, exp, f,
    output x, busy, done, tt, mismatch, first_fail, fail_count
  );
endinterface

// File: rtl/truth_table_scanner_counter.sv
// Minterm index plus per-minterm hold down-counter.
//   clk, reset : clock, async active-high reset
//   load       : restart at minterm 0 with a full hold period
//   advance    : count while scanning
//   index      : current minterm
//   sample_c   : hold counter expired, this edge samples the block outputs
//   last_c     : current minterm is the final one
module scan_counter
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned HOLD = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            advance,
  output logic [N_IN-1:0] index,
  output logic            sample_c,
  output logic            last_c
);
  localparam int unsigned M  = minterms(N_IN);
  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  logic [CW-1:0] hold_cnt;

  assign sample_c = (hold_cnt == '0);
  assign last_c   = (index == N_IN'(M - 1));

  // Index stops at the last minterm instead of wrapping; the FSM leaves SCAN there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= '0;
      hold_cnt <= '0;
    end else if (load) begin
      index    <= '0;
      hold_cnt <= RELOAD;
    end else if (advance) begin
      if (sample_c) begin
        if (!last_c) begin
          index    <= index + N_IN'(1);
          hold_cnt <= RELOAD;
        end
      end else begin
        hold_cnt <= hold_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives every minterm onto a small combinational block, captures one
// truth-table row per output and compares it with an expected table.
//   clk, reset : clock, async active-high reset
//   bus.start  : level request, accepted only when idle
//   bus.exp    : expected table, exp[j*M+m] = f[j] at minterm m
//   bus.f      : block outputs, sampled at the end of each hold period
//   bus.x      : block inputs (minterm index, MSB = first variable)
//   bus.busy   : scan in progress
//   bus.done   : one-cycle pulse at the final sample
//   bus.tt     : captured table, same packing as exp
//   bus.mismatch / first_fail / fail_count : comparison results
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_scanner_if.slave  bus
);
  localparam int unsigned M  = minterms(N_IN);
  localparam int unsigned TW = N_OUT * M;

  state_t          state;
  logic [TW-1:0]   exp_q;
  logic [N_IN-1:0] index;
  logic            sample_c;
  logic            last_c;
  logic            load;
  logic [TW-1:0]   tt_next;
  logic            minterm_miss;
  logic [M-1:0]    row;
  logic [M-1:0]    exp_row;

  assign load = (state == IDLE) && bus.start;

  scan_counter #(
    .N_IN (N_IN),
    .HOLD (HOLD)
  ) u_scan_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (state == SCAN),
    .index    (index),
    .sample_c (sample_c),
    .last_c   (last_c)
  );

  // Table with the current minterm's samples inserted, and whether any output missed.
  always_comb begin
    tt_next      = bus.tt;
    minterm_miss = 1'b0;
    row          = '0;
    exp_row      = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      row          = bus.tt[tt_index(j, 0, N_IN) +: M];
      exp_row      = exp_q[tt_index(j, 0, N_IN) +: M];
      row[index]   = bus.f[j];
      if (bus.f[j] != exp_row[index]) begin
        minterm_miss = 1'b1;
      end
      tt_next[tt_index(j, 0, N_IN) +: M] = row;
    end
  end

  // Scan FSM with registered outputs; x mirrors the counter index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      exp_q          <= '0;
      bus.x          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.tt         <= '0;
      bus.mismatch   <= 1'b0;
      bus.first_fail <= '0;
      bus.fail_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            exp_q          <= bus.exp;
            bus.tt         <= '0;
            bus.mismatch   <= 1'b0;
            bus.first_fail <= '0;
            bus.fail_count <= '0;
            bus.x          <= '0;
            bus.busy       <= 1'b1;
            state          <= SCAN;
          end
        end
        SCAN: begin
          if (sample_c) begin
            bus.tt <= tt_next;
            if (minterm_miss) begin
              bus.fail_count <= bus.fail_count + (N_IN + 1)'(1);
              if (!bus.mismatch) begin
                bus.first_fail <= index;
                bus.mismatch   <= 1'b1;
              end
            end
            if (last_c) begin
              bus.busy <= 1'b0;
              bus.x    <= '0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.x <= bus.x + N_IN'(1);
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed testbench for truth_table_scanner: table-driven scans plus
// hand-written reset, busy-start, HOLD=2 and back-to-back sequences.
module tb_truth_table_scanner;
  import truth_table_pkg::*;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 2;
  localparam logic [31:0] GOLD  = 32'hFF32_7731;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;
  logic [1:0] f_del1, f_del2;

  truth_table_scanner_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if1 ();
  truth_table_scanner_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if2 ();

  truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  // Reference combinational block; x[3] is the first variable.
  function automatic logic [1:0] model(input logic [3:0] m);
    logic a, b, c, d;
    {a, b, c, d} = m;
    model[0] = (a & ~c) | (b & ~c) | (~c & ~d) | (a & ~d);
    model[1] = (a | ~c) & (a | b | d) & (a | ~c | ~d);
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    f_del1 <= model(if1.x);
    f_del2 <= model(if2.x);
  end

  always_comb begin
    case (mode)
      0:       if1.f = 2'b00;
      1:       if1.f = model(if1.x);
      2:       if1.f = f_del1;
      default: if1.f = 2'b11;
    endcase
  end
  assign if2.f = f_del2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One scan on dut1; optionally pulse start and corrupt exp after pulse_at busy cycles.
  task automatic run_scan(input logic [31:0] e, input int pulse_at, output int nbusy);
    bit x_ok;
    int n;
    x_ok  = 1'b1;
    nbusy = 0;
    n     = 0;
    @(negedge clk);
    if1.exp   = e;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    while (if1.busy === 1'b1 && n < 200) begin
      if (if1.x !== 4'(nbusy)) x_ok = 1'b0;
      nbusy++;
      n++;
      if (nbusy == pulse_at) begin
        if1.start = 1'b1;
        if1.exp   = ~e;
      end else begin
        if1.start = 1'b0;
      end
      @(negedge clk);
    end
    if1.start = 1'b0;
    if1.exp   = e;
    chk("x_sequence", 64'(x_ok), 64'd1);
    chk("done_pulse", 64'(if1.done), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'({if1.done, if1.busy}), 64'd0);
  endtask

  typedef struct {
    int          mode;
    logic [31:0] exp;
    logic [31:0] tt;
    logic        mm;
    logic [3:0]  ff;
    logic [4:0]  fc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          nb;
    int          n;
    int          t0;
    logic [31:0] dly_tt;
    logic [3:0]  xr;

    vecs[0] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'd0,  5'd0};
    vecs[1] = '{1, GOLD,          GOLD,          1'b0, 4'd0,  5'd0};
    vecs[2] = '{1, 32'hFF32_7F31, GOLD,          1'b1, 4'd11, 5'd1};
    vecs[3] = '{0, GOLD,          32'h0000_0000, 1'b1, 4'd0,  5'd12};
    vecs[4] = '{3, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4'd0,  5'd16};

    reset     = 1'b1;
    if1.start = 1'b0;
    if1.exp   = '0;
    if2.start = 1'b0;
    if2.exp   = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {if1.x, if1.busy, if1.done, if1.mismatch, if1.first_fail,
                        if1.fail_count, if1.tt}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      run_scan(vecs[i].exp, -1, nb);
      chk($sformatf("v%0d_busy", i), 64'(nb), 64'd16);
      chk($sformatf("v%0d_tt", i), 64'(if1.tt), 64'(vecs[i].tt));
      chk($sformatf("v%0d_mismatch", i), 64'(if1.mismatch), 64'(vecs[i].mm));
      chk($sformatf("v%0d_first_fail", i), 64'(if1.first_fail), 64'(vecs[i].ff));
      chk($sformatf("v%0d_fail_count", i), 64'(if1.fail_count), 64'(vecs[i].fc));
    end

    // Registered block with HOLD=1: each sample sees the previous minterm's response.
    mode = 2;
    for (int m = 0; m < 16; m++) begin
      xr = (m == 0) ? 4'd0 : 4'(m - 1);
      {dly_tt[16 + m], dly_tt[m]} = model(xr);
    end
    run_scan(GOLD, -1, nb);
    chk("dly1_tt_differs", 64'(if1.tt != GOLD), 64'd1);
    chk("dly1_tt", 64'(if1.tt), 64'(dly_tt));
    chk("dly1_mismatch", 64'(if1.mismatch), 64'd1);

    // Registered block with HOLD=2 recovers the correct table.
    @(negedge clk);
    if2.exp   = GOLD;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    n = 0;
    while (if2.busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("h2_busy", 64'(n), 64'd32);
    chk("h2_done", 64'(if2.done), 64'd1);
    chk("h2_tt", 64'(if2.tt), 64'(GOLD));
    chk("h2_mismatch", 64'(if2.mismatch), 64'd0);

    // Asynchronous reset at minterm 7.
    mode = 1;
    @(negedge clk);
    if1.exp   = GOLD;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    n = 0;
    while (if1.x !== 4'd7 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("mid_reached_7", 64'({if1.x, if1.busy}), 64'({4'd7, 1'b1}));
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {if1.x, if1.busy, if1.done, if1.mismatch, if1.first_fail,
                              if1.fail_count, if1.tt}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh scan with a start pulse and exp change during busy.
    run_scan(GOLD, 5, nb);
    chk("pulse_busy", 64'(nb), 64'd16);
    chk("pulse_tt", 64'(if1.tt), 64'(GOLD));
    chk("pulse_results", 64'({if1.mismatch, if1.first_fail, if1.fail_count}), 64'd0);
    @(negedge clk);
    chk("pulse_no_rescan", 64'(if1.busy), 64'd0);

    // Start held high: back-to-back scans.
    @(negedge clk);
    if1.exp   = GOLD;
    if1.start = 1'b1;
    n = 0;
    while (if1.done !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    t0 = cyc;
    chk("b2b_first_done", 64'(if1.done), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_tt_cleared", 64'({if1.busy, if1.tt}), 64'({1'b1, 32'h0}));
    n = 0;
    while (if1.done !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_gap", 64'(cyc - t0), 64'd18);
    chk("b2b_tt", 64'(if1.tt), 64'(GOLD));
    if1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_idle", 64'({if1.busy, if1.done}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/response harness for small combinational logic blocks with N_IN inputs and N_OUT outputs. It drives the DUT inputs and reads the DUT outputs.
- On start, it drives every input minterm in ascending order, samples each DUT output, and builds one truth-table vector per output.
- It compares the captured table against an expected table and reports the mismatches.
- It sits beside a combinational function block in lab/bring-up designs, so one instance replaces hand-toggled switch tests.

Parameters:
N_IN, 4, number of DUT inputs; minterm count M = 2^N_IN
N_OUT, 2, number of DUT outputs
HOLD, 1, clock cycles each minterm is held on x before sampling; legal range >= 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  level; accepted only in IDLE
exp  input  N_OUT*M  expected table; exp[j*M + m] is the expected value of f[j] at minterm m; captured when start is accepted
f  input  N_OUT  DUT outputs; f[0] is the first function
x  output  N_IN  DUT inputs; x[N_IN-1] is the first variable (MSB), so minterm index m = x
busy  output  1  high while scanning
done  output  1  one-cycle pulse when a scan completes
tt  output  N_OUT*M  captured table, same packing as exp
mismatch  output  1  high if any captured bit differs from exp
first_fail  output  N_IN  lowest minterm with any output mismatch; 0 if none
fail_count  output  N_IN+1  number of minterms with at least one output mismatch

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state = IDLE.
  - x, busy, done, tt, mismatch, first_fail, fail_count, hold counter, index and exp register all = 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - x = 0, busy = 0.
  - Results from the previous scan hold.
  - start = 1 at an edge causes, at that edge:
    - exp captured;
    - tt, mismatch, first_fail, fail_count cleared;
    - index = 0, x = 0, hold counter = HOLD-1, busy = 1;
    - go to SCAN.
- SCAN:
  - x = index, stable for exactly HOLD cycles per minterm.
  - Hold counter counts down each edge.
  - At the edge where the counter is 0 (the sample edge), for each j: tt[j*M+index] <= f[j].
  - Minterm miss = (f != exp bits for index):
    - on a miss, fail_count increments;
    - on the first miss of the scan, first_fail <= index and mismatch <= 1.
  - If index < M-1: index and x increment, counter reloads to HOLD-1.
  - If index == M-1: go to DONE, busy <= 0, x <= 0, done <= 1.
  - index is N_IN bits wide; the terminal test prevents wrap. x never shows M after the last minterm.
- DONE: done = 1 for exactly this one cycle; start is ignored; next edge goes to IDLE.
- Timing:
  - scan length is M*HOLD cycles of busy;
  - done rises at the last sample edge;
  - with start held high, the next scan begins 2 cycles after done rises (DONE, then IDLE accept).
- start while busy or in DONE is ignored; exp changes during a scan have no effect.
- f is sampled only at sample edges; its value at other times is don't-care.
- fail_count saturates naturally at M (width N_IN+1 holds M).
- All outputs are registered; no combinational path from f or start to any output.

Decomposition:
- Shared package truth_table_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - a localparam function for M = 2^N_IN;
  - the packing-index helper j*M + m.
- One sub-module, scan_counter: minterm index plus HOLD down-counter, with load/advance inputs and sample/last outputs.
- Table capture and compare stay in the top module.

Test Plan:
- f tied to 2'b00, exp = 0, HOLD=1 -> x steps 0..15 one cycle each; busy high 16 cycles; done pulse at the 16th edge; tt = 0; mismatch = 0; fail_count = 0.
- DUT model: f[0] = x1x3' | x2x3' | x3'x4' | x1x4', f[1] = (x1|~x3)(x1|x2|x4)(x1|~x3|~x4), with exp = 0xFF32_7731 -> tt = 0xFF32_7731, mismatch = 0, first_fail = 0.
- Same model, exp = 0xFF32_7F31 (bit 11 of f[0] flipped) -> mismatch = 1, first_fail = 11, fail_count = 1, tt unchanged.
- Model delayed one register stage:
  - HOLD=1 -> tt differs from 0xFF32_7731 and mismatch = 1;
  - HOLD=2 -> tt = 0xFF32_7731, busy = 32 cycles.
- Assert reset when index = 7 -> all outputs 0 immediately; a pulse of start during busy in a subsequent scan is ignored; a fresh start yields a complete 16-minterm scan.
- start held high with the model from the second scenario -> back-to-back scans; done pulses 18 cycles apart; tt cleared at each new start and re-filled to 0xFF32_7731.
